// File: rtl/exe_pkg.sv
// Shared execute-stage definitions: RV32M/RV64M funct3 encodings,
// multiply/divide FSM states and the M-extension decode constants.
package exe_pkg;

    // Opcode and funct7 that identify an M-extension R-type instruction
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M      = 7'b0000001;

    // funct3 encodings of the M group
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/exe_muldiv.sv
// Multi-cycle M-extension unit: one-bit-per-cycle shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, with single-cycle handling
// of divide-by-zero and signed overflow, and a flush that aborts in-flight work.
module exe_muldiv
    import exe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [XLEN-1:0]    reg_wdata_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_op;
    logic [RADDR_W-1:0]    r_waddr;
    logic                  r_neg;
    logic [XLEN-1:0]       r_b;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]     r_acc;     // {partial hi, multiplier} or {remainder, quotient}
    logic                  r_done;
    logic [RADDR_W-1:0]    r_waddr_o;
    logic [XLEN-1:0]       r_wdata;

    logic                  w_is_div;
    logic                  w_sign1;
    logic                  w_sign2;
    logic [XLEN-1:0]       w_mag1;
    logic [XLEN-1:0]       w_mag2;
    logic                  w_neg;
    logic                  w_div0;
    logic                  w_ovf;
    logic                  w_fast;
    logic [XLEN-1:0]       w_fast_res;
    logic [XLEN:0]         w_sum;
    logic [XLEN:0]         w_diff;
    logic [2*XLEN-1:0]     w_mul_nxt;
    logic [2*XLEN-1:0]     w_div_nxt;
    logic [2*XLEN-1:0]     w_acc_nxt;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_quo;
    logic [XLEN-1:0]       w_rem;
    logic [XLEN-1:0]       w_result;

    // Request decode: operand signedness, magnitudes, result sign, fast paths
    always_comb begin
        w_is_div = md_is_div(op_i);
        w_sign1  = op1_i[XLEN-1] && (op_i == MD_MUL || op_i == MD_MULH || op_i == MD_MULHSU ||
                                     op_i == MD_DIV || op_i == MD_REM);
        w_sign2  = op2_i[XLEN-1] && (op_i == MD_MUL || op_i == MD_MULH ||
                                     op_i == MD_DIV || op_i == MD_REM);
        w_mag1   = w_sign1 ? -op1_i : op1_i;
        w_mag2   = w_sign2 ? -op2_i : op2_i;
        // Remainder takes the dividend's sign; everything else sign1 ^ sign2
        w_neg    = (op_i == MD_REM) ? w_sign1 : (w_sign1 ^ w_sign2);
        w_div0   = w_is_div && (op2_i == '0);
        w_ovf    = (op_i == MD_DIV || op_i == MD_REM) && (op1_i == MIN_NEG) && (op2_i == '1);
        w_fast   = w_div0 || w_ovf;
        if (w_div0)
            w_fast_res = op_i[1] ? op1_i : '1;
        else
            w_fast_res = op_i[1] ? '0 : op1_i;
    end

    // One iteration of either datapath, plus sign fix-up and word select of
    // the would-be final accumulator so the last iteration can retire directly
    always_comb begin
        w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
        w_mul_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
        w_diff    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
        w_div_nxt = !w_diff[XLEN] ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                                  : {r_acc[2*XLEN-2:0], 1'b0};
        w_acc_nxt = md_is_div(r_op) ? w_div_nxt : w_mul_nxt;
        w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
        w_quo     = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
        w_rem     = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
        case (r_op)
            MD_MUL:                       w_result = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_result = w_quo;
            default:                      w_result = w_rem;
        endcase
    end

    // Control FSM and datapath registers; flush beats completion
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_waddr   <= '0;
            r_neg     <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_waddr_o <= '0;
            r_wdata   <= '0;
        end else if (flush_i) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_op    <= op_i;
                        r_waddr <= reg_waddr_i;
                        r_neg   <= w_neg;
                        r_cnt   <= '0;
                        if (w_fast) begin
                            r_state   <= MD_DONE;
                            r_done    <= 1'b1;
                            r_wdata   <= w_fast_res;
                            r_waddr_o <= reg_waddr_i;
                        end else begin
                            r_state <= MD_CALC;
                            r_b     <= w_is_div ? w_mag2 : w_mag1;
                            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                        end
                    end
                end
                MD_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state   <= MD_DONE;
                        r_done    <= 1'b1;
                        r_wdata   <= w_result;
                        r_waddr_o <= r_waddr;
                    end
                end
                MD_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (r_state == MD_IDLE);
    assign busy_o      = !ready_o;
    assign done_o      = r_done;
    assign reg_we_o    = r_done;
    assign reg_waddr_o = r_waddr_o;
    assign reg_wdata_o = r_wdata;

endmodule
